// File: rtl/qrd_pkg.sv
// qrd_pkg: shared constants and state encoding for the QRD input feeder.
package qrd_pkg;
    localparam int IN_W         = 14;
    localparam int N            = 4;
    localparam int COLS         = 5;
    localparam int LAUNCH_LEN   = 46;
    localparam int ROW_OFF [4]  = '{0, 1, 21, 41};
    localparam int FLAG_OFF [3] = '{0, 2, 23};
    typedef enum logic [1:0] {LOAD, WAIT, LAUNCH} state_t;
endpackage

// File: rtl/qrd_elem_buf.sv
// qrd_elem_buf: element storage, one write port by load count, four
// asynchronous read ports (one per QRD row).
module qrd_elem_buf #(
    parameter int W     = 28,
    parameter int DEPTH = 20,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr [4],
    output logic [W-1:0]  o_rdata [4]
);
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    for (genvar g = 0; g < 4; g++) begin : g_rd
        assign o_rdata[g] = r_mem[i_raddr[g]];
    end
endmodule

// File: rtl/qrd_feeder.sv
// qrd_feeder: buffers one [H|y] matrix and launches it as skewed row
// streams into the QRD array, all outputs registered.
module qrd_feeder #(
    parameter int IN_W = qrd_pkg::IN_W,
    parameter int N    = qrd_pkg::N
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in_r,
    input  logic signed [IN_W-1:0] in_i,
    input  logic                   qrd_ready,
    output logic signed [IN_W-1:0] row_in_1_r,
    output logic signed [IN_W-1:0] row_in_1_i,
    output logic signed [IN_W-1:0] row_in_2_r,
    output logic signed [IN_W-1:0] row_in_2_i,
    output logic signed [IN_W-1:0] row_in_3_r,
    output logic signed [IN_W-1:0] row_in_3_i,
    output logic signed [IN_W-1:0] row_in_4_r,
    output logic signed [IN_W-1:0] row_in_4_i,
    output logic                   row_in_1_f,
    output logic                   row_in_2_f,
    output logic                   row_in_3_f,
    output logic                   launch_done
);
    import qrd_pkg::*;

    localparam int DEPTH = N * COLS;
    localparam int W     = 2 * IN_W;

    state_t       r_state, w_next;
    logic [4:0]   r_cnt;
    logic [5:0]   r_t, w_nt;
    logic         w_acc, w_go, w_last, w_nact;
    logic [3:0]   w_win;
    logic [4:0]   w_raddr [4];
    logic [W-1:0] w_rdata [4];
    logic [W-1:0] r_row [4];
    logic [2:0]   r_f;
    logic         r_done;

    assign w_acc  = in_valid && r_state == LOAD;
    assign w_go   = r_state == WAIT && qrd_ready;
    assign w_last = r_t == 6'(LAUNCH_LEN - 1);
    // w_nt is the launch index of the coming cycle, valid when w_nact
    assign w_nact = w_go || (r_state == LAUNCH && !w_last);
    assign w_nt   = w_go ? '0 : r_t + 6'd1;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= LOAD;
        else        r_state <= w_next;

    always_comb
        w_next = (w_acc && r_cnt == 5'(DEPTH - 1)) ? WAIT :
                 w_go                              ? LAUNCH :
                 (r_state == LAUNCH && w_last)     ? LOAD : r_state;

    always_comb in_ready = r_state == LOAD;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_cnt <= '0;
            r_t   <= '0;
        end else begin
            r_cnt <= !w_acc ? r_cnt : (r_cnt == 5'(DEPTH - 1)) ? '0 : r_cnt + 5'd1;
            r_t   <= (r_state == LAUNCH && !w_last) ? r_t + 6'd1 : '0;
        end

    qrd_elem_buf #(.W(W), .DEPTH(DEPTH), .AW(5)) u_buf (
        .clk     (clk),
        .i_we    (w_acc),
        .i_waddr (r_cnt),
        .i_wdata ({in_r, in_i}),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // column wraps past COLS when the row has not started yet
    for (genvar g = 0; g < 4; g++) begin : g_row
        logic [5:0] w_col;
        assign w_col      = w_nt - 6'(ROW_OFF[g]);
        assign w_win[g]   = w_nact && w_col < 6'(COLS);
        assign w_raddr[g] = w_win[g] ? 5'(g * COLS) + w_col[4:0] : '0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int j = 0; j < 4; j++) r_row[j] <= '0;
            r_f    <= '0;
            r_done <= 1'b0;
        end else begin
            for (int j = 0; j < 4; j++) r_row[j] <= w_win[j] ? w_rdata[j] : '0;
            for (int j = 0; j < 3; j++) r_f[j] <= w_nact && w_nt == 6'(FLAG_OFF[j]);
            r_done <= w_nact && w_nt == 6'(LAUNCH_LEN - 1);
        end

    assign row_in_1_r  = r_row[0][W-1:IN_W];
    assign row_in_1_i  = r_row[0][IN_W-1:0];
    assign row_in_2_r  = r_row[1][W-1:IN_W];
    assign row_in_2_i  = r_row[1][IN_W-1:0];
    assign row_in_3_r  = r_row[2][W-1:IN_W];
    assign row_in_3_i  = r_row[2][IN_W-1:0];
    assign row_in_4_r  = r_row[3][W-1:IN_W];
    assign row_in_4_i  = r_row[3][IN_W-1:0];
    assign row_in_1_f  = r_f[0];
    assign row_in_2_f  = r_f[1];
    assign row_in_3_f  = r_f[2];
    assign launch_done = r_done;
endmodule

// File: tb/tb_qrd_feeder.sv
// tb_qrd_feeder: directed vectors for the QRD feeder load/wait/launch flow.
module tb_qrd_feeder;
    localparam int W = 14;
    localparam int ROFF [4] = '{0, 1, 21, 41};
    localparam int FOFF [3] = '{0, 2, 23};

    typedef struct {
        int       t;
        int       r [4];
        bit [2:0] f;
        bit       dn;
    } vec_t;

    logic clk = 0, rst_n = 0, in_valid = 0, qrd_ready = 1;
    logic signed [W-1:0] in_r = 0, in_i = 0;
    logic in_ready;
    logic signed [W-1:0] row_in_1_r, row_in_1_i, row_in_2_r, row_in_2_i;
    logic signed [W-1:0] row_in_3_r, row_in_3_i, row_in_4_r, row_in_4_i;
    logic row_in_1_f, row_in_2_f, row_in_3_f, launch_done;

    int n_cmp = 0, n_bad = 0;
    int cap_r [4][46];
    int cap_i [4][46];
    bit cap_f [3][46];
    bit cap_d [46];
    vec_t vecs [12];

    qrd_feeder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_i(in_i), .qrd_ready(qrd_ready),
        .row_in_1_r(row_in_1_r), .row_in_1_i(row_in_1_i),
        .row_in_2_r(row_in_2_r), .row_in_2_i(row_in_2_i),
        .row_in_3_r(row_in_3_r), .row_in_3_i(row_in_3_i),
        .row_in_4_r(row_in_4_r), .row_in_4_i(row_in_4_i),
        .row_in_1_f(row_in_1_f), .row_in_2_f(row_in_2_f), .row_in_3_f(row_in_3_f),
        .launch_done(launch_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int ev(input int off, input bit cst, input int j, input int k, input bit im);
        if (cst) return im ? 8191 : -8192;
        return im ? -(off + 100 * j + k) : off + 100 * j + k;
    endfunction

    function automatic int outs_or();
        return int'(|{row_in_1_r, row_in_1_i, row_in_2_r, row_in_2_i, row_in_3_r, row_in_3_i,
                      row_in_4_r, row_in_4_i, row_in_1_f, row_in_2_f, row_in_3_f, launch_done});
    endfunction

    // called at a negedge in LOAD; returns at the negedge of the first WAIT cycle
    task automatic load(input int off, input bit cst, input bit gaps);
        for (int n = 0; n < 20; n++) begin
            chk("in_ready_load", int'(in_ready), 1);
            in_valid = 1;
            in_r = W'(ev(off, cst, n / 5, n % 5, 0));
            in_i = W'(ev(off, cst, n / 5, n % 5, 1));
            @(negedge clk);
            if (gaps && n < 19) begin
                in_valid = 0; in_r = 14'sd1234; in_i = -14'sd1234;
                @(negedge clk);
            end
        end
        in_valid = 1; in_r = 14'sd777; in_i = -14'sd777;
        chk("in_ready_wait", int'(in_ready), 0);
    endtask

    task automatic capture(input int upto);
        for (int t = 0; t < upto; t++) begin
            @(negedge clk);
            cap_r[0][t] = int'(row_in_1_r); cap_i[0][t] = int'(row_in_1_i);
            cap_r[1][t] = int'(row_in_2_r); cap_i[1][t] = int'(row_in_2_i);
            cap_r[2][t] = int'(row_in_3_r); cap_i[2][t] = int'(row_in_3_i);
            cap_r[3][t] = int'(row_in_4_r); cap_i[3][t] = int'(row_in_4_i);
            cap_f[0][t] = row_in_1_f; cap_f[1][t] = row_in_2_f; cap_f[2][t] = row_in_3_f;
            cap_d[t] = launch_done;
            chk($sformatf("in_ready_launch t=%0d", t), int'(in_ready), 0);
        end
        in_valid = 0;
        if (upto == 46) begin
            @(negedge clk);
            chk("in_ready_after", int'(in_ready), 1);
        end
    endtask

    task automatic check_table();
        foreach (vecs[v]) begin
            int t;
            t = vecs[v].t;
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("tbl row%0d_r t=%0d", j + 1, t), cap_r[j][t], vecs[v].r[j]);
                chk($sformatf("tbl row%0d_i t=%0d", j + 1, t), cap_i[j][t], -vecs[v].r[j]);
            end
            for (int j = 0; j < 3; j++)
                chk($sformatf("tbl f%0d t=%0d", j + 1, t), int'(cap_f[j][t]), int'(vecs[v].f[j]));
            chk($sformatf("tbl done t=%0d", t), int'(cap_d[t]), int'(vecs[v].dn));
        end
    endtask

    task automatic check_all(input string tag, input int off, input bit cst);
        for (int t = 0; t < 46; t++) begin
            for (int j = 0; j < 4; j++) begin
                bit inw;
                inw = t >= ROFF[j] && t < ROFF[j] + 5;
                chk($sformatf("%s row%0d_r t=%0d", tag, j + 1, t), cap_r[j][t],
                    inw ? ev(off, cst, j, t - ROFF[j], 0) : 0);
                chk($sformatf("%s row%0d_i t=%0d", tag, j + 1, t), cap_i[j][t],
                    inw ? ev(off, cst, j, t - ROFF[j], 1) : 0);
            end
            for (int j = 0; j < 3; j++)
                chk($sformatf("%s f%0d t=%0d", tag, j + 1, t), int'(cap_f[j][t]), int'(t == FOFF[j]));
            chk($sformatf("%s done t=%0d", tag, t), int'(cap_d[t]), int'(t == 45));
        end
    endtask

    initial begin
        vecs[0]  = '{0,  '{0, 0, 0, 0},     3'b001, 1'b0};
        vecs[1]  = '{1,  '{1, 100, 0, 0},   3'b000, 1'b0};
        vecs[2]  = '{2,  '{2, 101, 0, 0},   3'b010, 1'b0};
        vecs[3]  = '{4,  '{4, 103, 0, 0},   3'b000, 1'b0};
        vecs[4]  = '{5,  '{0, 104, 0, 0},   3'b000, 1'b0};
        vecs[5]  = '{6,  '{0, 0, 0, 0},     3'b000, 1'b0};
        vecs[6]  = '{21, '{0, 0, 200, 0},   3'b000, 1'b0};
        vecs[7]  = '{23, '{0, 0, 202, 0},   3'b100, 1'b0};
        vecs[8]  = '{25, '{0, 0, 204, 0},   3'b000, 1'b0};
        vecs[9]  = '{26, '{0, 0, 0, 0},     3'b000, 1'b0};
        vecs[10] = '{41, '{0, 0, 0, 300},   3'b000, 1'b0};
        vecs[11] = '{45, '{0, 0, 0, 304},   3'b000, 1'b1};

        #12;
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset outputs", outs_or(), 0);
        @(negedge clk);
        rst_n = 1;

        load(0, 0, 0);
        capture(46);
        check_table();
        check_all("m1", 0, 0);

        load(50, 0, 0);
        capture(46);
        check_all("b2b", 50, 0);

        load(0, 0, 1);
        capture(46);
        check_table();
        check_all("gaps", 0, 0);

        qrd_ready = 0;
        load(0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("wait in_ready c=%0d", i), int'(in_ready), 0);
            chk($sformatf("wait outputs c=%0d", i), outs_or(), 0);
            @(negedge clk);
        end
        qrd_ready = 1;
        capture(46);
        check_all("ext", 0, 1);

        load(0, 0, 0);
        capture(23);
        chk("pre-reset row3_r t=22", cap_r[2][22], 201);
        #1 rst_n = 0;
        #1;
        chk("async reset outputs", outs_or(), 0);
        chk("async reset in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1;
        load(7, 0, 0);
        capture(46);
        check_all("post-rst", 7, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/qrd_feeder.md
QRD_FEEDER -- requirements
Module: qrd_feeder

Interface
REQ-001 SHALL provide parameter IN_W, default 14, meaning signed width of each real/imag component.
REQ-002 SHALL provide parameter N, default 4, meaning matrix order (H is NxN, y appended as column N).
REQ-003 SHALL: clk  input  1  single clock, all flops rising-edge.
REQ-004 SHALL: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL: in_valid  input  1  element strobe from upstream.
REQ-006 SHALL: in_ready  output  1  feeder accepts an element this cycle.
REQ-007 SHALL: in_r, in_i  input  IN_W each  signed element, row-major [H(j,0..3), y(j)], j=0..3.
REQ-008 SHALL: qrd_ready  input  1  downstream QRD array may start a new matrix.
REQ-009 SHALL: row_in_1_r/_i .. row_in_4_r/_i  output  IN_W each  skewed row streams to QRD.
REQ-010 SHALL: row_in_1_f, row_in_2_f, row_in_3_f  output  1 each  diagonal-element marker per row.
REQ-011 SHALL: launch_done  output  1  one-cycle pulse at the last launch cycle.

Function
REQ-012 SHALL implement states LOAD, WAIT, LAUNCH; in_ready = 1 exactly when state is LOAD.
REQ-013 SHALL store an element on each cycle with in_valid & in_ready; 5-bit load count 0..19; in_valid gaps tolerated, no loss or duplication.
REQ-014 SHALL go LOAD->WAIT on the cycle the 20th element (count 19) is accepted; in_ready is 0 the next cycle.
REQ-015 SHALL go WAIT->LAUNCH when qrd_ready=1 in WAIT; remain in WAIT, outputs all zero, otherwise.
REQ-016 SHALL number LAUNCH cycles t=0..45, t=0 being the first cycle state reads LAUNCH.
REQ-017 SHALL drive row_in_1 = element(0,t) for t=0..4; row_in_2 = element(1,t-1) for t=1..5; row_in_3 = element(2,t-21) for t=21..25; row_in_4 = element(3,t-41) for t=41..45; zero otherwise.
REQ-018 SHALL assert row_in_1_f only at t=0, row_in_2_f only at t=2, row_in_3_f only at t=23 (diagonal element of each row).
REQ-019 SHALL drive all row_in_* and flag outputs directly from flops (values for cycle t are precomputed in cycle t-1).
REQ-020 SHALL assert launch_done at t=45 and go LAUNCH->LOAD after it, count cleared; buffer contents need not be cleared.
REQ-021 SHALL ignore qrd_ready outside WAIT and in_valid outside LOAD.
REQ-022 SHALL pass element values unmodified (no rounding, saturation or sign change).

Reset
REQ-023 SHALL, on rst_n=0 at any time including mid-LAUNCH, force state LOAD, load count 0, t count 0, all row_in_* and flags 0, launch_done 0.
REQ-024 SHALL make in_ready 1 in the first cycle after rst_n deasserts; a partially loaded or launched matrix is discarded.
REQ-025 SHALL not require reset of the element buffer storage.

Structure
REQ-026 SHALL place IN_W, N, COLS=5, LAUNCH_LEN=46, row start offsets {0,1,21,41}, flag offsets {0,2,23} and the state enum in shared package qrd_pkg.
REQ-027 SHALL isolate the 20-entry x 2*IN_W element storage (write port indexed by load count, four read ports indexed by row/column) in sub-module qrd_elem_buf.

Verification
REQ-028 Load elements (j,k) with real = 100*j+k, imag = -(100*j+k) back-to-back, qrd_ready=1 -> t=0 row_in_1 = 0/0, f1=1; t=2 row_in_2 = 101/-101, f2=1; t=23 row_in_3 = 202/-202, f3=1; t=45 row_in_4 = 304/-304, launch_done=1.
REQ-029 Same data with in_valid toggling every other cycle -> identical launch outputs; in_ready=0 from the cycle after the 20th acceptance until after t=45.
REQ-030 Hold qrd_ready=0 for 10 cycles after load -> state WAIT, all outputs zero, in_ready=0; launch t=0 begins the cycle after qrd_ready is first sampled 1.
REQ-031 Assert rst_n=0 at t=22 -> all outputs 0 asynchronously; after release in_ready=1; a fresh 20-element load launches correctly.
REQ-032 Two matrices back-to-back (second load starting at first launch_done+1) -> second launch starts 21 cycles after load resumes with qrd_ready=1; values from matrix 2 only.
REQ-033 Inputs -8192 and 8191 in every slot -> emitted unchanged; all non-window cycles emit exactly 0.
